// File: rtl/ahb_pkg.sv
// AHB protocol encodings shared by the arbiter and its helpers.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;
  localparam logic [1:0] HRESP_RETRY = 2'd2;
  localparam logic [1:0] HRESP_SPLIT = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam int BEAT_W = 5;

  // Number of address phases in a burst; undefined-length bursts count as one
  // because they may be broken at any beat.
  function automatic logic [BEAT_W-1:0] burst_len(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
      default:                      burst_len = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Rotating priority encoder: first set request strictly after ptr_i, with wrap.
// The pointer slot itself is scanned last, so a lone requester can be re-picked.
module ahb_rr_pick #(
  parameter  int NUM_MASTERS = 4,
  localparam int IW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IW-1:0]          ptr_i,
  output logic                   valid_o,
  output logic [IW-1:0]          idx_o
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int off = NUM_MASTERS; off >= 1; off--) begin
      int unsigned slot;
      slot = (int'(ptr_i) + off) % NUM_MASTERS;
      if (req_i[IW'(slot)]) idx_o = IW'(slot);
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant, fixed bursts kept whole except on
// ERROR/RETRY/SPLIT, locked sequences honoured. Owner (HMASTER) trails the
// grant by one accepted cycle.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MW             = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);
  import ahb_pkg::*;

  localparam int                     IW      = $clog2(NUM_MASTERS);
  localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [MW-1:0]          gnt_idx_q,    gnt_idx_d;
  logic [MW-1:0]          rr_ptr_q,     rr_ptr_d;
  logic [NUM_MASTERS-1:0] hgrant_q,     hgrant_d;
  logic [MW-1:0]          hmaster_q,    hmaster_d;
  logic                   hmastlock_q,  hmastlock_d;
  logic [BEAT_W-1:0]      beats_left_q, beats_left_d;

  logic          resp_err, err_first, burst_busy, lock_hold, arb_point;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  // SPLIT is handled exactly like RETRY; the first response cycle has HREADY low.
  assign resp_err  = (HRESP == HRESP_ERROR) || (HRESP == HRESP_RETRY) ||
                     (HRESP == HRESP_SPLIT);
  assign err_first = !HREADY && resp_err;

  // With one beat left the grant may move while that last SEQ is accepted;
  // a BUSY (or anything else) on the last beat still holds it.
  assign burst_busy = (beats_left_q > 5'd1) ||
                      ((beats_left_q == 5'd1) && (HTRANS != HTRANS_SEQ));

  // Registered lock keeps the grant one transfer past HLOCK dropping.
  assign lock_hold = HLOCK[gnt_idx_q[IW-1:0]] || hmastlock_q;

  assign arb_point = !lock_hold && ((HREADY && !burst_busy) || err_first);

  ahb_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req_i   (HBUSREQ),
    .ptr_i   (rr_ptr_q[IW-1:0]),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Beat tracking: error response wins over any load/decrement.
  always_comb begin
    beats_left_d = beats_left_q;
    if (err_first)
      beats_left_d = '0;
    else if (HREADY && (HTRANS == HTRANS_NONSEQ))
      beats_left_d = burst_len(HBURST) - 5'd1;
    else if (HREADY && (HTRANS == HTRANS_SEQ) && (beats_left_q != '0))
      beats_left_d = beats_left_q - 5'd1;
  end

  // Grant selection; idle bus parks on the default master without moving rr.
  always_comb begin
    gnt_idx_d = gnt_idx_q;
    rr_ptr_d  = rr_ptr_q;
    if (arb_point) begin
      if (pick_valid) begin
        gnt_idx_d = MW'(pick_idx);
        rr_ptr_d  = MW'(pick_idx);
      end else begin
        gnt_idx_d = DEF_IDX;
      end
    end
    hgrant_d = '0;
    hgrant_d[gnt_idx_d[IW-1:0]] = 1'b1;
  end

  // Ownership advances only on accepted cycles.
  always_comb begin
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    if (HREADY) begin
      hmaster_d   = gnt_idx_q;
      hmastlock_d = HLOCK[gnt_idx_q[IW-1:0]];
    end
  end

  // State registers, asynchronously reset to the default owner.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt_idx_q    <= DEF_IDX;
      rr_ptr_q     <= DEF_IDX;
      hgrant_q     <= DEF_GNT;
      hmaster_q    <= DEF_IDX;
      hmastlock_q  <= 1'b0;
      beats_left_q <= '0;
    end else begin
      gnt_idx_q    <= gnt_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      hgrant_q     <= hgrant_d;
      hmaster_q    <= hmaster_d;
      hmastlock_q  <= hmastlock_d;
      beats_left_q <= beats_left_d;
    end
  end

  assign HGRANT    = hgrant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: reset, round-robin, fixed burst hold,
// error rearbitration, locked sequence, asynchronous reset mid-burst.
module tb_ahb_arbiter;

  logic       HCLK, HRESETn;
  logic [3:0] HBUSREQ, HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [1:0] HRESP;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  int checks = 0;
  int errors = 0;

  ahb_arbiter #(.NUM_MASTERS(4), .MW(2), .DEFAULT_MASTER(0)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  initial begin
    HCLK = 0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    HBUSREQ = 4'b0000; HLOCK = 4'b0000;
    HTRANS = 2'd0; HBURST = 3'd0; HREADY = 1'b1; HRESP = 2'd0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    idle_inputs();
    step(); step();
    checks++; if (HGRANT !== 4'b0001) begin errors++; $display("FAIL reset_gnt got %b want 0001", HGRANT); end
    checks++; if (HMASTER !== 2'd0) begin errors++; $display("FAIL reset_master got %0d want 0", HMASTER); end
    checks++; if (HMASTLOCK !== 1'b0) begin errors++; $display("FAIL reset_lock got %b want 0", HMASTLOCK); end
    @(negedge HCLK); HRESETn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      HREADY = i[0];
      step();
      checks++;
      if (HGRANT !== 4'b0001 || HMASTER !== 2'd0) begin
        errors++; $display("FAIL idle_park cyc %0d got gnt %b mst %0d want 0001 0", i, HGRANT, HMASTER);
      end
    end
    HREADY = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [4];
    logic [1:0] exp_m [4];
    exp_g = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
    exp_m = '{2'd0, 2'd1, 2'd2, 2'd1};
    HBUSREQ = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (HGRANT !== exp_g[i] || HMASTER !== exp_m[i]) begin
        errors++; $display("FAIL rr_seq %0d got gnt %b mst %0d want %b %0d", i, HGRANT, HMASTER, exp_g[i], exp_m[i]);
      end
      if (i == 1) begin HTRANS = 2'd2; HBURST = 3'd0; end
    end
    HREADY = 1'b0;
    step();
    checks++;
    if (HGRANT !== 4'b0100 || HMASTER !== 2'd1) begin
      errors++; $display("FAIL rr_wait got gnt %b mst %0d want 0100 1", HGRANT, HMASTER);
    end
    HREADY = 1'b1; HBUSREQ = 4'b0000; HTRANS = 2'd0;
    step();
    checks++;
    if (HGRANT !== 4'b0001 || HMASTER !== 2'd2) begin
      errors++; $display("FAIL rr_park got gnt %b mst %0d want 0001 2", HGRANT, HMASTER);
    end
    step();
  endtask

  task automatic test_burst();
    HBUSREQ = 4'b0010;
    step();
    checks++; if (HGRANT !== 4'b0010) begin errors++; $display("FAIL burst_gnt got %b want 0010", HGRANT); end
    step();
    checks++; if (HMASTER !== 2'd1) begin errors++; $display("FAIL burst_owner got %0d want 1", HMASTER); end
    HTRANS = 2'd2; HBURST = 3'd3;
    step();
    checks++; if (dut.beats_left_q !== 5'd3) begin errors++; $display("FAIL burst_load got %0d want 3", dut.beats_left_q); end
    HBUSREQ = 4'b1010; HTRANS = 2'd3;
    step();
    checks++; if (HGRANT !== 4'b0010) begin errors++; $display("FAIL burst_hold2 got %b want 0010", HGRANT); end
    step();
    checks++; if (HGRANT !== 4'b0010) begin errors++; $display("FAIL burst_hold3 got %b want 0010", HGRANT); end
    HTRANS = 2'd1;
    step();
    checks++;
    if (HGRANT !== 4'b0010 || dut.beats_left_q !== 5'd1) begin
      errors++; $display("FAIL burst_busy_last got gnt %b beats %0d want 0010 1", HGRANT, dut.beats_left_q);
    end
    HTRANS = 2'd3;
    step();
    checks++;
    if (HGRANT !== 4'b1000 || HMASTER !== 2'd1) begin
      errors++; $display("FAIL burst_release got gnt %b mst %0d want 1000 1", HGRANT, HMASTER);
    end
    HBUSREQ = 4'b1000; HTRANS = 2'd0;
    step();
    checks++; if (HMASTER !== 2'd3) begin errors++; $display("FAIL burst_next_owner got %0d want 3", HMASTER); end
    HBUSREQ = 4'b0000;
    step(); step();
  endtask

  task automatic test_error();
    HBUSREQ = 4'b0100;
    step();
    checks++; if (HGRANT !== 4'b0100) begin errors++; $display("FAIL err_gnt got %b want 0100", HGRANT); end
    step();
    HTRANS = 2'd2; HBURST = 3'd5;
    step();
    HBUSREQ = 4'b1100; HTRANS = 2'd3;
    step();
    checks++;
    if (HGRANT !== 4'b0100 || dut.beats_left_q !== 5'd6) begin
      errors++; $display("FAIL err_pre got gnt %b beats %0d want 0100 6", HGRANT, dut.beats_left_q);
    end
    HREADY = 1'b0; HRESP = 2'd1;
    step();
    checks++;
    if (HGRANT !== 4'b1000 || HMASTER !== 2'd2 || dut.beats_left_q !== 5'd0) begin
      errors++; $display("FAIL err_first got gnt %b mst %0d beats %0d want 1000 2 0", HGRANT, HMASTER, dut.beats_left_q);
    end
    HBUSREQ = 4'b1000; HREADY = 1'b1; HTRANS = 2'd0;
    step();
    checks++;
    if (HGRANT !== 4'b1000 || HMASTER !== 2'd3) begin
      errors++; $display("FAIL err_second got gnt %b mst %0d want 1000 3", HGRANT, HMASTER);
    end
    HRESP = 2'd0; HBUSREQ = 4'b0000;
    step(); step();
  endtask

  task automatic test_lock();
    HBUSREQ = 4'b0110; HLOCK = 4'b0010;
    step();
    checks++;
    if (HGRANT !== 4'b0010 || HMASTLOCK !== 1'b0) begin
      errors++; $display("FAIL lock_gnt got gnt %b lk %b want 0010 0", HGRANT, HMASTLOCK);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (HGRANT !== 4'b0010 || HMASTER !== 2'd1 || HMASTLOCK !== 1'b1) begin
        errors++; $display("FAIL lock_xfer %0d got gnt %b mst %0d lk %b want 0010 1 1", i, HGRANT, HMASTER, HMASTLOCK);
      end
      if (i == 0) begin HTRANS = 2'd2; HBURST = 3'd0; end
    end
    HLOCK = 4'b0000; HBUSREQ = 4'b0100;
    step();
    checks++;
    if (HGRANT !== 4'b0010 || HMASTLOCK !== 1'b0) begin
      errors++; $display("FAIL lock_extra got gnt %b lk %b want 0010 0", HGRANT, HMASTLOCK);
    end
    HTRANS = 2'd0;
    step();
    checks++;
    if (HGRANT !== 4'b0100 || HMASTER !== 2'd1) begin
      errors++; $display("FAIL lock_release got gnt %b mst %0d want 0100 1", HGRANT, HMASTER);
    end
    step();
    checks++; if (HMASTER !== 2'd2) begin errors++; $display("FAIL lock_next_owner got %0d want 2", HMASTER); end
    HBUSREQ = 4'b0000;
    step(); step();
  endtask

  task automatic test_reset_mid_burst();
    HBUSREQ = 4'b1000;
    step(); step();
    checks++; if (HMASTER !== 2'd3) begin errors++; $display("FAIL rst_owner got %0d want 3", HMASTER); end
    HTRANS = 2'd2; HBURST = 3'd7;
    step();
    HTRANS = 2'd3;
    step();
    checks++; if (dut.beats_left_q !== 5'd14) begin errors++; $display("FAIL rst_pre_beats got %0d want 14", dut.beats_left_q); end
    #2 HRESETn = 1'b0;
    #1;
    checks++;
    if (HGRANT !== 4'b0001 || HMASTER !== 2'd0 || HMASTLOCK !== 1'b0 || dut.beats_left_q !== 5'd0) begin
      errors++; $display("FAIL rst_async got gnt %b mst %0d lk %b beats %0d want 0001 0 0 0",
                         HGRANT, HMASTER, HMASTLOCK, dut.beats_left_q);
    end
    HTRANS = 2'd0; HBUSREQ = 4'b1001;
    @(negedge HCLK); HRESETn = 1'b1;
    step();
    checks++;
    if (HGRANT !== 4'b1000 || HMASTER !== 2'd0) begin
      errors++; $display("FAIL rst_restart got gnt %b mst %0d want 1000 0", HGRANT, HMASTER);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst();
    test_error();
    test_lock();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
